// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver (8N1) with a one-entry valid/ready holding register
// and sticky error flags. Defining UART_RX_PARITY_EN adds an even-parity bit (8E1) and parity_err_o.
module uart_rx_core #(
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic [DIV_W-1:0] clk_div_i,
    input  logic             rx_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    input  logic             err_clr_i,
    output logic             frame_err_o,
    output logic             overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic             parity_err_o,
`endif
    output logic             busy_o
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] START_MID = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] BIT_MID   = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] BIT_LAST  = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef UART_RX_PARITY_EN
    function automatic logic even_parity_err(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
`endif

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_last_q;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [OS_W-1:0]        os_q, os_d;
    logic [1:0]             samp_q, samp_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q;
    logic                   valid_q, frame_q, ovr_q, busy_q;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d, par_set_s, par_q;
`endif
    logic                   rx_s, fall_s, tick_s, maj_s, accept_s, commit_s, frame_set_s;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign fall_s   = rx_last_q & ~rx_s;
    assign tick_s   = (state_q != ST_IDLE) && (cnt_q == {DIV_W{1'b0}});
    // samp_q holds the two previous tick samples, so this is the 3-tick vote ending now
    assign maj_s    = majority3(samp_q[1], samp_q[0], rx_s);
    assign accept_s = valid_q & rx_ready_i;

    // Next-state logic for the tick generator, bit sampler and frame FSM.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        os_d        = os_q;
        samp_d      = samp_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        commit_s    = 1'b0;
        frame_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        par_set_s   = 1'b0;
`endif
        if (state_q == ST_IDLE) begin
            cnt_d = div_q;
            os_d  = {OS_W{1'b0}};
        end else if (tick_s) begin
            cnt_d  = div_q;
            os_d   = os_q + OS_W'(1);
            samp_d = {samp_q[0], rx_s};
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    state_d = ST_START;
                    div_d   = clk_div_i;
                    cnt_d   = clk_div_i;
                    bit_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // A valid start bit is confirmed at mid-bit but DATA begins with the next bit period
            ST_START: begin
                if (tick_s && (os_q == START_MID) && maj_s) begin
                    state_d = ST_IDLE;
                end else if (tick_s && (os_q == BIT_LAST)) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s && (os_q == BIT_MID)) begin
                    shift_d = {maj_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_s && (os_q == BIT_MID)) begin
                    state_d = ST_STOP;
                    if (even_parity_err(shift_q, maj_s)) begin
                        par_set_s = 1'b1;
                        par_bad_d = 1'b1;
                    end else begin
                        par_bad_d = par_bad_q;
                    end
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s && (os_q == BIT_MID)) begin
                    if (maj_s) begin
`ifdef UART_RX_PARITY_EN
                        commit_s = ~par_bad_q;
`else
                        commit_s = 1'b1;
`endif
                        state_d  = ST_IDLE;
                    end else begin
                        frame_set_s = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Input synchronizer, edge history and receive datapath state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            sync_q    <= {SYNC_STAGES{1'b1}};
            rx_last_q <= 1'b1;
            state_q   <= ST_IDLE;
            div_q     <= {DIV_W{1'b0}};
            cnt_q     <= {DIV_W{1'b0}};
            os_q      <= {OS_W{1'b0}};
            samp_q    <= 2'b11;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_last_q <= rx_s;
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            os_q      <= os_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Holding register, sticky flags and busy indication; a flag set beats a same-cycle clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            busy_q <= (state_q != ST_IDLE);
            if (commit_s && (!valid_q || accept_s)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (accept_s) begin
                valid_q <= 1'b0;
            end
            if (commit_s && valid_q && !accept_s) begin
                ovr_q <= 1'b1;
            end else if (err_clr_i) begin
                ovr_q <= 1'b0;
            end
            if (frame_set_s) begin
                frame_q <= 1'b1;
            end else if (err_clr_i) begin
                frame_q <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            if (par_set_s) begin
                par_q <= 1'b1;
            end else if (err_clr_i) begin
                par_q <= 1'b0;
            end
`endif
        end
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = frame_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = par_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: serial frames are generated at the bit level and the
// received bytes/flags are compared with expectations derived from the frame contents.
module tb_uart_rx_core;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Negedge (counted from the one driving the start bit) whose cycle holds the stop decision:
    // 2 sync flops + 1 edge-detect cycle, then mid-point of the stop bit.
    localparam int COMMIT_NEG = 3 + (NBITS - 1) * OS + OS / 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] clk_div;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        err_clr;
    logic        frame_err;
    logic        overrun;
    logic        busy;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
    logic        par_flip = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    int fe_rises = 0;
    logic fe_prev = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx_core #(.OVERSAMPLE(OS), .DIV_W(16), .SYNC_STAGES(2)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .clk_div_i   (clk_div),
        .rx_i        (rx),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .rx_ready_i  (rx_ready),
        .err_clr_i   (err_clr),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err_o(parity_err),
`endif
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Observe handshakes and flag edges between clock edges.
    always @(negedge clk) begin
        #1;
        fe_prev <= frame_err;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (rx_valid) valid_cycles <= valid_cycles + 1;
        if (frame_err && !fe_prev) fe_rises <= fe_rises + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_rx(input string tag);
        check({tag, " byte count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, " byte"}, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at the current negedge; leaves the line high.
    task automatic send(input logic [7:0] b, input logic stop_bit, input int bitc);
        rx = 1'b0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bitc) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (bitc) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (bitc) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rx_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, " rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, " frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, " overrun"}, {31'd0, overrun}, 32'd0);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
`ifdef UART_RX_PARITY_EN
        check({tag, " parity_err"}, {31'd0, parity_err}, 32'd0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int d, vc0, fe0;
        rst_n = 1'b0; rx = 1'b1; clk_div = 16'd0; rx_ready = 1'b1; err_clr = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2 * OS);

        // Basic byte with immediate accept: one-cycle valid, no flags
        vc0 = valid_cycles;
        send(8'hA5, 1'b1, OS); exp_q.push_back(8'hA5);
        idle(2 * OS);
        compare_rx("a5");
        check("a5 valid cycles", valid_cycles - vc0, 32'd1);
        check("a5 frame_err", {31'd0, frame_err}, 32'd0);
        check("a5 overrun", {31'd0, overrun}, 32'd0);
        check("a5 busy idle", {31'd0, busy}, 32'd0);

        // Random bytes, random divisors, random inter-frame gaps (including back-to-back)
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            d = $urandom_range(0, 2);
            clk_div = 16'(d);
            send(b, 1'b1, (d + 1) * OS); exp_q.push_back(b);
            idle($urandom_range(0, 2) * (d + 1) * OS);
        end
        idle(6 * OS);
        compare_rx("random");

        // Divisor changed mid-frame must not disturb the frame in flight
        b = 8'($urandom);
        clk_div = 16'd1;
        fork
            send(b, 1'b1, 2 * OS);
            begin repeat (5 * OS) @(negedge clk); clk_div = 16'd3; end
        join
        exp_q.push_back(b);
        idle(4 * OS);
        clk_div = 16'd0;
        idle(OS);
        compare_rx("div change");

        // Short glitch: false start
        vc0 = valid_cycles;
        rx = 1'b0; repeat (4) @(negedge clk);
        rx = 1'b1; repeat (3) @(negedge clk);
        check("glitch busy high", {31'd0, busy}, 32'd1);
        idle(40);
        check("glitch busy low", {31'd0, busy}, 32'd0);
        check("glitch no valid", valid_cycles - vc0, 32'd0);
        check("glitch frame_err", {31'd0, frame_err}, 32'd0);

        // Bad stop bit followed by a long break: exactly one frame error
        vc0 = valid_cycles; fe0 = fe_rises;
        send(8'h3C, 1'b0, OS);
        rx = 1'b0;
        repeat (40 * OS) @(negedge clk);
        check("break busy", {31'd0, busy}, 32'd1);
        idle(2 * OS);
        check("break frame_err", {31'd0, frame_err}, 32'd1);
        check("break one error", fe_rises - fe0, 32'd1);
        check("break no valid", valid_cycles - vc0, 32'd0);
        check("break busy low", {31'd0, busy}, 32'd0);
        send(8'h55, 1'b1, OS); exp_q.push_back(8'h55);
        idle(2 * OS);
        compare_rx("after break");
        check("frame_err sticky", {31'd0, frame_err}, 32'd1);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        idle(2);
        check("frame_err cleared", {31'd0, frame_err}, 32'd0);

        // Overrun: second byte dropped, first held
        rx_ready = 1'b0;
        send(8'h11, 1'b1, OS); idle(OS);
        send(8'h22, 1'b1, OS); idle(2 * OS);
        check("ovr valid", {31'd0, rx_valid}, 32'd1);
        check("ovr data held", {24'd0, rx_data}, 32'h11);
        check("ovr flag", {31'd0, overrun}, 32'd1);
        compare_rx("ovr none accepted");
        rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        idle(2);
        compare_rx("ovr drain");
        check("ovr drained valid", {31'd0, rx_valid}, 32'd0);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        idle(2);
        check("ovr cleared", {31'd0, overrun}, 32'd0);

        // Accept in the very cycle the next byte commits: no overrun
        send(8'h11, 1'b1, OS); idle(OS);
        fork
            send(8'h22, 1'b1, OS);
            begin
                repeat (COMMIT_NEG) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        exp_q.push_back(8'h11);
        idle(2 * OS);
        compare_rx("same-cycle accept");
        check("same-cycle valid", {31'd0, rx_valid}, 32'd1);
        check("same-cycle data", {24'd0, rx_data}, 32'h22);
        check("same-cycle overrun", {31'd0, overrun}, 32'd0);

        // Reset during bit 4 of a frame; outputs clear, next frame received cleanly
        b = 8'($urandom);
        fork
            send(b, 1'b1, OS);
            begin
                repeat (5 * OS + OS / 2) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check_all_zero("mid-frame reset");
            end
        join
        idle(OS);
        rst_n = 1'b1;
        idle(2 * OS);
        rx_ready = 1'b1;
        send(8'h7E, 1'b1, OS); exp_q.push_back(8'h7E);
        idle(2 * OS);
        compare_rx("after reset");
        check("after reset frame_err", {31'd0, frame_err}, 32'd0);
        check("after reset overrun", {31'd0, overrun}, 32'd0);

`ifdef UART_RX_PARITY_EN
        // Wrong parity: byte discarded, sticky flag; correct parity: byte delivered
        vc0 = valid_cycles;
        par_flip = 1'b1;
        send(8'h0F, 1'b1, OS);
        par_flip = 1'b0;
        idle(2 * OS);
        check("parity err set", {31'd0, parity_err}, 32'd1);
        check("parity no valid", valid_cycles - vc0, 32'd0);
        send(8'h0F, 1'b1, OS); exp_q.push_back(8'h0F);
        idle(2 * OS);
        compare_rx("parity ok");
        check("parity err sticky", {31'd0, parity_err}, 32'd1);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        idle(2);
        check("parity err cleared", {31'd0, parity_err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
